hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Backward-direction control for the five-stage pipeline latches (fetch, decode, execute, memory, writeback).
- Latches carry instruction state forward; this block consumes the downstream destination/control fields and drives enables, bubbles, forwarding selects and PC control back upstream.
- Owns load-use stalls, data-memory wait, branch/jump flush with in-flight fetch redirect, and sticky halt.
- Placed beside the datapath between the latch registers and the PC/forwarding muxes.

Parameters:
CNT_W, 32, width of saturating stall/flush performance counters

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
ihit  in  1  instruction memory returned a word this cycle
dhit  in  1  data memory completed access this cycle
dec_rs  in  5  rs of instruction in decode
dec_rt  in  5  rt of instruction in decode
dec_uses_rt  in  1  decode instruction reads rt
ex_regDest  in  5  execute-stage destination
ex_regWen  in  1  execute-stage register write
ex_memRen  in  1  execute-stage instruction is a load
ex_redirect  in  1  branch taken or jump resolved in execute
mem_regDest  in  5  memory-stage destination
mem_regWen  in  1  memory-stage register write
mem_memRen  in  1  memory-stage read
mem_memWen  in  1  memory-stage write
mem_halt  in  1  halt reached memory stage
wb_regDest  in  5  writeback destination
wb_regWen  in  1  writeback register write
pc_en  out  1  PC register load enable
pc_hold_target  out  1  PC mux keeps latched redirect target
if_en, dec_en, ex_en, mem_en  out  1 each  latch enables (fetch/decode, decode/execute, execute/memory, memory/writeback)
dec_flush  out  1  load bubble into fetch/decode latch
ex_flush  out  1  load bubble into decode/execute latch
fwd_a  out  2  porta source: 00 regfile, 01 memory-stage aluOut, 10 writeback data
fwd_b  out  2  portb source, same encoding
halt  out  1  sticky processor halt
stall_cnt  out  CNT_W  cycles with any latch held
flush_cnt  out  CNT_W  bubbles inserted by redirect

Behaviour:
- State register: RUN, DWAIT, REDIRECT, HALT. RST on a clock edge -> RUN. Counters 0, halt 0. Outputs in RUN with no hazard: all enables 1, pc_en 1, flush 0, hold 0, fwd 00.
- Forwarding is combinational and state-independent. Operand reg 0 never forwards. Memory-stage match (mem_regWen, mem_regDest==src) beats writeback match. fwd_b applies only when dec_uses_rt, else 00.
- Load-use: ex_memRen & ex_regWen & ex_regDest!=0 & (ex_regDest==dec_rs | (dec_uses_rt & ex_regDest==dec_rt)).
  - Action: pc_en=0, if_en=0, dec_en=1, ex_flush=1. Exactly one bubble; no state change.
- Priority in RUN, highest first: mem_halt, data wait, ex_redirect, load-use, !ihit.
  - mem_halt: next HALT; mem_en=1 this cycle so halting instruction retires.
  - Data wait: (mem_memRen|mem_memWen) & !dhit. All enables 0, pc_en 0, next DWAIT.
  - ex_redirect with ihit: pc_en=1, dec_flush=1, ex_flush=1, flush_cnt += 2, stay RUN.
  - ex_redirect with !ihit: same flushes and pc_en=0, pc_hold_target=1, next REDIRECT. The wrong-path fetch is in flight.
  - !ihit alone: pc_en=0, dec_flush=1; downstream enables 1.
- DWAIT: all enables and pc_en 0 until dhit. On dhit, normal RUN evaluation applies that same cycle (zero-bubble exit); next RUN. mem_halt seen in DWAIT is honoured only after dhit.
- REDIRECT: pc_hold_target=1, dec_flush=1 every cycle. On ihit, the arriving word is discarded (dec_flush=1), pc_en=1 loads target, next RUN. A data wait in REDIRECT freezes all latches; REDIRECT is kept.
- HALT: all enables 0, pc_en 0, halt=1 until RST.
- stall_cnt increments on any cycle where pc_en=0 and state!=HALT. Both counters saturate at all-ones.
- Reset mid-DWAIT/REDIRECT: RUN next cycle, no residual hold.

Test Plan:
- lw $2 in EX, add $3,$2,$4 in decode -> one cycle if_en=0, ex_flush=1, pc_en=0; next cycle fwd_a=01.
- mem_regDest=5 and wb_regDest=5 both writing, dec_rs=5 -> fwd_a=01. With dec_rs=0 and both dests 0 -> fwd_a=00.
- sw in MEM, dhit low 3 cycles -> enables 0 for 3 cycles, stall_cnt=3, resume on the dhit cycle.
- ex_redirect with ihit=0 for 2 cycles -> REDIRECT, pc_hold_target=1 three cycles, word discarded on ihit, flush_cnt=2.
- mem_halt=1 -> mem_en=1 that cycle, then halt=1 permanently; RST clears halt next edge.
- RST asserted during DWAIT -> RUN, counters 0, all enables 1 the following cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Backward-flowing pipeline control: latch enables, bubbles, operand forwarding,
// PC redirect hold, data-memory wait, sticky halt and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       dec_rs,
  input  logic [4:0]       dec_rt,
  input  logic             dec_uses_rt,
  input  logic [4:0]       ex_regDest,
  input  logic             ex_regWen,
  input  logic             ex_memRen,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_regDest,
  input  logic             mem_regWen,
  input  logic             mem_memRen,
  input  logic             mem_memWen,
  input  logic             mem_halt,
  input  logic [4:0]       wb_regDest,
  input  logic             wb_regWen,
  output logic             pc_en,
  output logic             pc_hold_target,
  output logic             if_en,
  output logic             dec_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             dec_flush,
  output logic             ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_DWAIT    = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;
  localparam logic [1:0] S_HALT     = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       flush_inc;
  logic       data_wait;
  logic       load_use;
  logic       do_run;

  // Memory-stage producer wins over writeback; register 0 is hardwired and never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       mwen,
                                         input logic [4:0] mdst,
                                         input logic       wwen,
                                         input logic [4:0] wdst);
    if (src == 5'd0)                    return 2'b00;
    else if (mwen && (mdst == src))     return 2'b01;
    else if (wwen && (wdst == src))     return 2'b10;
    else                                return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign fwd_a = fwd_sel(dec_rs, mem_regWen, mem_regDest, wb_regWen, wb_regDest);
  assign fwd_b = dec_uses_rt ? fwd_sel(dec_rt, mem_regWen, mem_regDest, wb_regWen, wb_regDest)
                             : 2'b00;

  assign data_wait = (mem_memRen || mem_memWen) && !dhit;
  assign load_use  = ex_memRen && ex_regWen && (ex_regDest != 5'd0) &&
                     ((ex_regDest == dec_rs) || (dec_uses_rt && (ex_regDest == dec_rt)));
  // A completing data wait falls straight into normal evaluation in the same cycle.
  assign do_run    = (state == S_RUN) || ((state == S_DWAIT) && dhit);
  assign halt      = (state == S_HALT);

  always_comb begin
    pc_en          = 1'b1;
    pc_hold_target = 1'b0;
    if_en          = 1'b1;
    dec_en         = 1'b1;
    ex_en          = 1'b1;
    mem_en         = 1'b1;
    dec_flush      = 1'b0;
    ex_flush       = 1'b0;
    flush_inc      = 1'b0;
    state_nxt      = state;
    if (do_run) begin
      state_nxt = S_RUN;
      if (mem_halt) begin
        pc_en     = 1'b0;
        if_en     = 1'b0;
        dec_en    = 1'b0;
        ex_en     = 1'b0;
        state_nxt = S_HALT;
      end else if (data_wait) begin
        pc_en     = 1'b0;
        if_en     = 1'b0;
        dec_en    = 1'b0;
        ex_en     = 1'b0;
        mem_en    = 1'b0;
        state_nxt = S_DWAIT;
      end else if (ex_redirect) begin
        dec_flush = 1'b1;
        ex_flush  = 1'b1;
        flush_inc = 1'b1;
        if (!ihit) begin
          pc_en          = 1'b0;
          pc_hold_target = 1'b1;
          state_nxt      = S_REDIRECT;
        end
      end else if (load_use) begin
        pc_en    = 1'b0;
        if_en    = 1'b0;
        ex_flush = 1'b1;
      end else if (!ihit) begin
        pc_en     = 1'b0;
        dec_flush = 1'b1;
      end
    end else begin
      case (state)
        S_REDIRECT: begin
          // The wrong-path word still in flight is squashed when it lands.
          pc_hold_target = 1'b1;
          dec_flush      = 1'b1;
          if (mem_halt) begin
            pc_en     = 1'b0;
            if_en     = 1'b0;
            dec_en    = 1'b0;
            ex_en     = 1'b0;
            state_nxt = S_HALT;
          end else if (data_wait) begin
            pc_en  = 1'b0;
            if_en  = 1'b0;
            dec_en = 1'b0;
            ex_en  = 1'b0;
            mem_en = 1'b0;
          end else if (ihit) begin
            state_nxt = S_RUN;
          end else begin
            pc_en = 1'b0;
          end
        end
        default: begin
          pc_en  = 1'b0;
          if_en  = 1'b0;
          dec_en = 1'b0;
          ex_en  = 1'b0;
          mem_en = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!pc_en && (state != S_HALT)) stall_cnt <= sat_add(stall_cnt, 2'd1);
      if (flush_inc)                   flush_cnt <= sat_add(flush_cnt, 2'd2);
    end
  end

endmodule
